// File: rtl/aq_lsu_fence_resp_if.sv
// -----------------------------------------------------------------------------
// aq_lsu_fence_resp_if
//   Groups the CP0 fence/sync handshake, the LSU drain-status inputs, the BIU
//   write-channel events and the responder outputs into one bundle.
//
//   Signals:
//     cp0_lsu_fence_req     CP0 -> LSU  fence request (level, held until ack)
//     cp0_lsu_sync_req      CP0 -> LSU  sync/synci request (level, held until ack)
//     sq_empty              SQ  -> LSU  store queue empty
//     wmb_empty             WMB -> LSU  write-merge buffer empty
//     ld_pipe_idle          LSU         no load in flight
//     lsu_biu_aw_issue      LSU -> BIU  write address handshake this cycle
//     biu_lsu_b_vld         BIU -> LSU  write response this cycle
//     lsu_cp0_fence_ack     LSU -> CP0  one-cycle fence acknowledge
//     lsu_cp0_sync_ack      LSU -> CP0  one-cycle sync acknowledge
//     lsu_fence_issue_stall LSU         blocks new load/store issue
//     lsu_wr_outst_full     LSU         outstanding-write counter at maximum
//     lsu_fence_cur_state   LSU         FSM state for debug / hpcp
//
//   Modports:
//     slave  - the fence responder
//     master - the surrounding environment (CP0, SQ, WMB, BIU)
// -----------------------------------------------------------------------------
interface aq_lsu_fence_resp_if;
  logic       cp0_lsu_fence_req;
  logic       cp0_lsu_sync_req;
  logic       sq_empty;
  logic       wmb_empty;
  logic       ld_pipe_idle;
  logic       lsu_biu_aw_issue;
  logic       biu_lsu_b_vld;
  logic       lsu_cp0_fence_ack;
  logic       lsu_cp0_sync_ack;
  logic       lsu_fence_issue_stall;
  logic       lsu_wr_outst_full;
  logic [2:0] lsu_fence_cur_state;

  modport slave (
    input  cp0_lsu_fence_req,
    input  cp0_lsu_sync_req,
    input  sq_empty,
    input  wmb_empty,
    input  ld_pipe_idle,
    input  lsu_biu_aw_issue,
    input  biu_lsu_b_vld,
    output lsu_cp0_fence_ack,
    output lsu_cp0_sync_ack,
    output lsu_fence_issue_stall,
    output lsu_wr_outst_full,
    output lsu_fence_cur_state
  );

  modport master (
    output cp0_lsu_fence_req,
    output cp0_lsu_sync_req,
    output sq_empty,
    output wmb_empty,
    output ld_pipe_idle,
    output lsu_biu_aw_issue,
    output biu_lsu_b_vld,
    input  lsu_cp0_fence_ack,
    input  lsu_cp0_sync_ack,
    input  lsu_fence_issue_stall,
    input  lsu_wr_outst_full,
    input  lsu_fence_cur_state
  );
endinterface

// File: rtl/aq_lsu_fence_resp.sv
// -----------------------------------------------------------------------------
// aq_lsu_fence_resp
//   LSU-side responder for the CP0 fence/sync handshake. On a request it stalls
//   new memory-op issue, waits for the SQ, WMB and load pipe to drain, and for
//   sync also waits for all outstanding bus writes to complete, then returns a
//   one-cycle registered acknowledge. A request that drops before the ack is an
//   abort and is never acknowledged.
//
//   Ports:
//     forever_cpuclk  LSU clock
//     cpurst_b        synchronous active-low reset
//     bus             aq_lsu_fence_resp_if.slave (handshake, drain status,
//                     BIU write events, acks, stall, debug state)
//
//   Parameters:
//     OUTST_W         width of the outstanding-bus-write counter
//
//   Build option:
//     AQ_LSU_FENCE_WAIT_BUS_EN  when defined, fence also waits in WBUS for
//                               outstanding bus writes, same as sync.
// -----------------------------------------------------------------------------
module aq_lsu_fence_resp #(
  parameter int unsigned OUTST_W = 3
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  aq_lsu_fence_resp_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_DRAIN = 3'b001,
    ST_WBUS  = 3'b010,
    ST_ACK   = 3'b011,
    ST_WLOW  = 3'b100
  } state_t;

`ifdef AQ_LSU_FENCE_WAIT_BUS_EN
  localparam logic FENCE_WAIT_BUS = 1'b1;
`else
  localparam logic FENCE_WAIT_BUS = 1'b0;
`endif

  localparam logic [OUTST_W-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_is_sync;
  logic                 w_is_sync_nxt;
  logic                 r_fence_ack;
  logic                 r_sync_ack;
  logic                 r_stall;
  logic [OUTST_W-1:0]   r_outst_cnt;

  logic                 w_any_req;
  logic                 w_drained;
  logic                 w_bus_idle;

  assign w_any_req  = bus.cp0_lsu_fence_req | bus.cp0_lsu_sync_req;
  assign w_drained  = bus.sq_empty & bus.wmb_empty & bus.ld_pipe_idle;
  assign w_bus_idle = (r_outst_cnt == '0) & ~bus.biu_lsu_b_vld;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = ST_IDLE;
    w_is_sync_nxt = r_is_sync;
    case (r_state)
      ST_IDLE: begin
        // Sync wins when both requests are seen together.
        w_is_sync_nxt = bus.cp0_lsu_sync_req;
        w_state_nxt   = w_any_req ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        // A sync arriving on top of a pending fence upgrades it.
        if (bus.cp0_lsu_sync_req) begin
          w_is_sync_nxt = 1'b1;
        end
        if (!w_any_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_drained) begin
          w_state_nxt = (w_is_sync_nxt || FENCE_WAIT_BUS) ? ST_WBUS : ST_ACK;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_WBUS: begin
        if (!w_any_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bus_idle) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_WBUS;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_WLOW;
      end
      ST_WLOW: begin
        // Hold here until CP0 drops the request so a held level is acked once.
        w_state_nxt = w_any_req ? ST_WLOW : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs. Acks and stall are decoded from the next
  // state so they come straight from flops with the same timing as a decode of
  // the current state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_state     <= ST_IDLE;
      r_is_sync   <= 1'b0;
      r_fence_ack <= 1'b0;
      r_sync_ack  <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_is_sync   <= w_is_sync_nxt;
      r_fence_ack <= (w_state_nxt == ST_ACK) & ~w_is_sync_nxt;
      r_sync_ack  <= (w_state_nxt == ST_ACK) &  w_is_sync_nxt;
      r_stall     <= (w_state_nxt == ST_DRAIN) | (w_state_nxt == ST_WBUS) |
                     (w_state_nxt == ST_ACK);
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding bus-write counter; saturates at both ends on protocol errors.
  // ---------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_outst_cnt <= '0;
    end else begin
      case ({bus.lsu_biu_aw_issue, bus.biu_lsu_b_vld})
        2'b10: begin
          if (r_outst_cnt != CNT_MAX) begin
            r_outst_cnt <= r_outst_cnt + 1'b1;
          end
        end
        2'b01: begin
          if (r_outst_cnt != '0) begin
            r_outst_cnt <= r_outst_cnt - 1'b1;
          end
        end
        default: begin
          r_outst_cnt <= r_outst_cnt;
        end
      endcase
    end
  end

  assign bus.lsu_cp0_fence_ack     = r_fence_ack;
  assign bus.lsu_cp0_sync_ack      = r_sync_ack;
  assign bus.lsu_fence_issue_stall = r_stall;
  assign bus.lsu_wr_outst_full     = (r_outst_cnt == CNT_MAX);
  assign bus.lsu_fence_cur_state   = r_state;

endmodule
